// File: rtl/sensor_cmd_pkg.sv
// Shared definitions for the sensor command controller: command/response
// codes, FSM states and the layout of a 40-bit DHT11 reading.
package sensor_cmd_pkg;

  localparam logic [7:0] CMD_STATUS   = 8'h00;
  localparam logic [7:0] CMD_TEMP     = 8'h01;
  localparam logic [7:0] CMD_HUM      = 8'h02;
  localparam logic [7:0] CMD_MON_TEMP = 8'h03;
  localparam logic [7:0] CMD_MON_HUM  = 8'h04;
  localparam logic [7:0] CMD_MON_OFF  = 8'h05;

  localparam logic [7:0] RSP_OK       = 8'h07;
  localparam logic [7:0] RSP_SNS_ERR  = 8'h1F;
  localparam logic [7:0] RSP_TEMP     = 8'h09;
  localparam logic [7:0] RSP_HUM      = 8'h08;
  localparam logic [7:0] RSP_MON_OFF  = 8'h0A;
  localparam logic [7:0] RSP_BAD_ADDR = 8'hFE;
  localparam logic [7:0] RSP_BAD_CMD  = 8'hFF;

  localparam int HUM_I_LSB  = 32;
  localparam int HUM_F_LSB  = 24;
  localparam int TEMP_I_LSB = 16;
  localparam int TEMP_F_LSB = 8;
  localparam int CHK_LSB    = 0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT_B1ST, ST_DECODE, ST_START, ST_WAIT_SNS,
    ST_BUILD, ST_TX0, ST_WAIT0, ST_TX1, ST_WAIT1
  } state_t;

  // The sensor checksum is the 8-bit wrapping sum of the four data bytes.
  function automatic logic chk_ok(input logic [39:0] w);
    logic [7:0] s;
    s = w[HUM_I_LSB +: 8] + w[HUM_F_LSB +: 8] + w[TEMP_I_LSB +: 8] + w[TEMP_F_LSB +: 8];
    return s == w[CHK_LSB +: 8];
  endfunction

endpackage

// File: rtl/cmd_frame_rx.sv
// Assembles (address, command) byte pairs from the UART RX stream and drops
// a half-received frame when the second byte takes too long to arrive.
module cmd_frame_rx #(
  parameter int RX_GAP_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       frame_valid,
  output logic       pending_next,
  output logic [7:0] addr,
  output logic [7:0] cmd
);

  localparam int GAP_W = $clog2(RX_GAP_CYCLES + 1);

  logic             have_q, have_d;
  logic [7:0]       addr_q, addr_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      have_q <= 1'b0;
      addr_q <= '0;
      gap_q  <= '0;
    end else begin
      have_q <= have_d;
      addr_q <= addr_d;
      gap_q  <= gap_d;
    end
  end

  // An expired partial frame is discarded; a byte arriving in that same
  // cycle is treated as the address of a fresh frame.
  always_comb begin
    have_d      = have_q;
    addr_d      = addr_q;
    gap_d       = gap_q;
    frame_valid = 1'b0;
    if (!have_q) begin
      gap_d = '0;
      if (rx_valid && ready) begin
        have_d = 1'b1;
        addr_d = rx_data;
      end
    end else if (gap_q == GAP_W'(RX_GAP_CYCLES)) begin
      gap_d  = '0;
      have_d = rx_valid && ready;
      if (rx_valid && ready) addr_d = rx_data;
    end else if (rx_valid && ready) begin
      frame_valid = 1'b1;
      have_d      = 1'b0;
      gap_d       = '0;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  assign pending_next = have_d;
  assign addr         = addr_q;
  assign cmd          = rx_data;

endmodule

// File: rtl/sensor_cmd_ctrl.sv
// Command controller: decodes UART frames, runs reads on DHT11-class channels
// and returns a two-byte (code, data) response, with a periodic monitor mode.
module sensor_cmd_ctrl
  import sensor_cmd_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int RX_GAP_CYCLES  = 50_000_000,
  parameter int SENSOR_TIMEOUT = 5_000_000,
  parameter int MON_PERIOD     = 100_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [N_CH-1:0]   sensor_start,
  input  logic [N_CH-1:0]   sensor_done,
  input  logic [N_CH*40-1:0] sensor_data,
  output logic              busy,
  output logic              mon_active
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMO_W = $clog2(SENSOR_TIMEOUT + 1);
  localparam int MON_W = (MON_PERIOD > 1) ? $clog2(MON_PERIOD) : 1;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d, cmd_q, cmd_d, code_q, code_d, data_q, data_d;
  logic [39:0]      snap_q, snap_d;
  logic             snap_v_q, snap_v_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mon_active_q, mon_active_d, mon_pend_q, mon_pend_d;
  logic [CH_W-1:0]  mon_ch_q, mon_ch_d;
  logic [7:0]       mon_kind_q, mon_kind_d;
  logic [MON_W-1:0] mon_cnt_q, mon_cnt_d;

  logic            rx_ready, frame_valid, pending_next, mon_tick;
  logic [7:0]      frm_addr, frm_cmd;
  logic [CH_W-1:0] ch;

  assign rx_ready   = (state_q == ST_IDLE) || (state_q == ST_WAIT_B1ST);
  assign busy       = !rx_ready;
  assign mon_active = mon_active_q;
  assign ch         = addr_q[CH_W-1:0];
  assign mon_tick   = mon_active_q && (mon_cnt_q == MON_W'(MON_PERIOD - 1));

  cmd_frame_rx #(.RX_GAP_CYCLES(RX_GAP_CYCLES)) u_frame_rx (
    .clock        (clock),
    .reset        (reset),
    .ready        (rx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .frame_valid  (frame_valid),
    .pending_next (pending_next),
    .addr         (frm_addr),
    .cmd          (frm_cmd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cmd_q        <= '0;
      code_q       <= '0;
      data_q       <= '0;
      snap_q       <= '0;
      snap_v_q     <= 1'b0;
      tmo_q        <= '0;
      mon_active_q <= 1'b0;
      mon_pend_q   <= 1'b0;
      mon_ch_q     <= '0;
      mon_kind_q   <= '0;
      mon_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      code_q       <= code_d;
      data_q       <= data_d;
      snap_q       <= snap_d;
      snap_v_q     <= snap_v_d;
      tmo_q        <= tmo_d;
      mon_active_q <= mon_active_d;
      mon_pend_q   <= mon_pend_d;
      mon_ch_q     <= mon_ch_d;
      mon_kind_q   <= mon_kind_d;
      mon_cnt_q    <= mon_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    code_d       = code_q;
    data_d       = data_q;
    snap_d       = snap_q;
    snap_v_d     = 1'b0;
    tmo_d        = tmo_q;
    mon_active_d = mon_active_q;
    mon_pend_d   = mon_pend_q;
    mon_ch_d     = mon_ch_q;
    mon_kind_d   = mon_kind_q;
    mon_cnt_d    = '0;
    sensor_start = '0;
    tx_start     = 1'b0;
    tx_data      = '0;

    // Ticks arriving while busy collapse into a single pending read.
    if (mon_active_q) begin
      mon_cnt_d = mon_tick ? '0 : mon_cnt_q + MON_W'(1);
      if (mon_tick) mon_pend_d = 1'b1;
    end else begin
      mon_pend_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_WAIT_B1ST: begin
        if (frame_valid) begin
          addr_d  = frm_addr;
          cmd_d   = frm_cmd;
          state_d = ST_DECODE;
        end else if (pending_next) begin
          state_d = ST_WAIT_B1ST;
        end else if (state_q == ST_IDLE && mon_pend_q) begin
          mon_pend_d = mon_tick;
          addr_d     = 8'(mon_ch_q);
          cmd_d      = mon_kind_q;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        state_d = ST_TX0;
        if (cmd_q > CMD_MON_OFF) begin
          code_d = RSP_BAD_CMD;
          data_d = 8'h00;
        end else if (cmd_q == CMD_MON_OFF) begin
          mon_active_d = 1'b0;
          code_d       = RSP_MON_OFF;
          data_d       = addr_q;
        end else if (addr_q >= 8'(N_CH)) begin
          code_d = RSP_BAD_ADDR;
          data_d = addr_q;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        sensor_start[ch] = 1'b1;
        tmo_d            = '0;
        state_d          = ST_WAIT_SNS;
      end
      ST_WAIT_SNS: begin
        if (sensor_done[ch] && !snap_v_q) begin
          snap_v_d = 1'b1;
          snap_d   = sensor_data[40*int'(ch) +: 40];
        end
        if (snap_v_q) begin
          state_d = ST_BUILD;
        end else if (tmo_q + TMO_W'(1) == TMO_W'(SENSOR_TIMEOUT)) begin
          code_d  = RSP_SNS_ERR;
          data_d  = 8'h00;
          state_d = ST_TX0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_BUILD: begin
        state_d = ST_TX0;
        code_d  = RSP_SNS_ERR;
        data_d  = 8'h00;
        if (chk_ok(snap_q)) begin
          case (cmd_q)
            CMD_STATUS: code_d = RSP_OK;
            CMD_TEMP, CMD_MON_TEMP: begin
              code_d = RSP_TEMP;
              data_d = snap_q[TEMP_I_LSB +: 8];
            end
            CMD_HUM, CMD_MON_HUM: begin
              code_d = RSP_HUM;
              data_d = snap_q[HUM_I_LSB +: 8];
            end
            default: code_d = RSP_SNS_ERR;
          endcase
          if (cmd_q == CMD_MON_TEMP || cmd_q == CMD_MON_HUM) begin
            mon_active_d = 1'b1;
            mon_ch_d     = ch;
            mon_kind_d   = cmd_q;
          end
        end
      end
      ST_TX0: begin
        tx_start = 1'b1;
        tx_data  = code_q;
        state_d  = ST_WAIT0;
      end
      ST_WAIT0: begin
        tx_data = code_q;
        if (tx_done) state_d = ST_TX1;
      end
      ST_TX1: begin
        tx_start = 1'b1;
        tx_data  = data_q;
        state_d  = ST_WAIT1;
      end
      ST_WAIT1: begin
        tx_data = data_q;
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sensor_cmd_ctrl.sv
// Scoreboard bench for sensor_cmd_ctrl: expected TX bytes are queued with each
// command and compared as the controller emits them.
module tb_sensor_cmd_ctrl;

  localparam int N_CH = 4;
  localparam int GAP  = 50;
  localparam int TMO  = 100;
  localparam int MON  = 1000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic [N_CH-1:0]   sensor_start;
  logic [N_CH-1:0]   sensor_done = '0;
  logic [N_CH*40-1:0] sensor_data = '0;
  logic              busy;
  logic              mon_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int starts[N_CH];
  int last_start_cyc = 0;
  int prev_start_cyc = 0;
  int done_cyc = 0;
  int sns_delay = 10;
  bit sns_enable = 1'b1;
  bit sns_wrong = 1'b0;
  bit tx_auto = 1'b1;
  logic [7:0] exp_q[$];

  sensor_cmd_ctrl #(
    .N_CH(N_CH), .RX_GAP_CYCLES(GAP), .SENSOR_TIMEOUT(TMO), .MON_PERIOD(MON)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done      (tx_done),
    .sensor_start (sensor_start),
    .sensor_done  (sensor_done),
    .sensor_data  (sensor_data),
    .busy         (busy),
    .mon_active   (mon_active)
  );

  initial forever #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard: every tx_start must match the next queued byte.
  initial begin : tx_monitor
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        tx_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL tx_unexpected got 0x%02h required no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("[TB] FAIL tx_byte got 0x%02h required 0x%02h", tx_data, e);
          end
        end
      end
    end
  end

  // UART TX model: acknowledges each byte a few cycles later and flags any
  // tx_start issued while a byte is still outstanding.
  initial begin : tx_responder
    bit seen;
    bit extra;
    forever begin
      @(negedge clock);
      seen = (tx_start === 1'b1);
      while (seen && tx_auto) begin
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          if (tx_start === 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra) begin
          errors++;
          $display("[TB] FAIL tx_start_while_waiting got 1 required 0");
        end
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        seen = (tx_start === 1'b1);
      end
    end
  end

  // Sensor model: counts starts per channel and answers with a done pulse.
  initial begin : sensor_model
    int ch;
    for (int k = 0; k < N_CH; k++) starts[k] = 0;
    forever begin
      @(negedge clock);
      if (sensor_start !== '0) begin
        checks++;
        if ($countones(sensor_start) != 1) begin
          errors++;
          $display("[TB] FAIL sensor_onehot got %b required one-hot", sensor_start);
        end
        ch = 0;
        for (int k = 0; k < N_CH; k++) if (sensor_start[k]) begin
          starts[k]++;
          ch = k;
        end
        prev_start_cyc = last_start_cyc;
        last_start_cyc = cyc;
        @(negedge clock);
        checks++;
        if (sensor_start !== '0) begin
          errors++;
          $display("[TB] FAIL sensor_pulse_width got %b required 0", sensor_start);
        end
        if (sns_enable) begin
          repeat (sns_delay - 1) @(negedge clock);
          sensor_done[sns_wrong ? 0 : ch] = 1'b1;
          done_cyc = cyc;
          @(negedge clock);
          sensor_done = '0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c);
    send_byte(a);
    send_byte(c);
  endtask

  task automatic set_sensor(input int ch, input logic [39:0] w);
    sensor_data[40*ch +: 40] = w;
  endtask

  task automatic expect_rsp(input logic [7:0] code, input logic [7:0] data);
    exp_q.push_back(code);
    exp_q.push_back(data);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy === 1'b1) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_timeout got %0d bytes pending busy=%b required 0 pending busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({tx_start, tx_data, sensor_start, busy, mon_active} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got tx_start=%b tx_data=%02h sensor_start=%b busy=%b mon=%b required all 0",
               tx_start, tx_data, sensor_start, busy, mon_active);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({tx_start, sensor_start, busy, mon_active} !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got busy=%b mon=%b required 0", busy, mon_active);
    end
  endtask

  task automatic test_temp_read();
    int n = 0;
    int base[N_CH];
    for (int k = 0; k < N_CH; k++) base[k] = starts[k];
    set_sensor(2, {8'h3C, 8'h00, 8'h19, 8'h00, 8'h55});
    expect_rsp(8'h09, 8'h19);
    send_frame(8'h02, 8'h01);
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (cyc - done_cyc != 3) begin
      errors++;
      $display("[TB] FAIL sensor_latency got %0d required 3", cyc - done_cyc);
    end
    wait_quiet("temp_read", 200);
    for (int k = 0; k < N_CH; k++) begin
      checks++;
      if (starts[k] - base[k] != ((k == 2) ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL temp_start_count ch%0d got %0d required %0d",
                 k, starts[k] - base[k], (k == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_status_hum();
    set_sensor(0, {8'hF0, 8'h20, 8'h15, 8'h05, 8'h2A});
    set_sensor(1, {8'h41, 8'h00, 8'h18, 8'h00, 8'h59});
    expect_rsp(8'h07, 8'h00);
    send_frame(8'h00, 8'h00);
    wait_quiet("status_wrap", 200);
    expect_rsp(8'h08, 8'h41);
    send_frame(8'h01, 8'h02);
    wait_quiet("hum_read", 200);
  endtask

  task automatic test_decode_errors();
    logic [7:0] ta[5] = '{8'h05, 8'h04, 8'h00, 8'h00, 8'h09};
    logic [7:0] tc[5] = '{8'h01, 8'h02, 8'h07, 8'h06, 8'h09};
    logic [7:0] tk[5] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] td[5] = '{8'h05, 8'h04, 8'h00, 8'h00, 8'h00};
    int total = 0;
    int n;
    for (int k = 0; k < N_CH; k++) total += starts[k];
    for (int i = 0; i < 5; i++) begin
      expect_rsp(tk[i], td[i]);
      send_frame(ta[i], tc[i]);
      n = 0;
      while (tx_start !== 1'b1 && n < 20) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (n + 1 != 2) begin
        errors++;
        $display("[TB] FAIL decode_latency case%0d got %0d required 2", i, n + 1);
      end
      wait_quiet("decode_err", 100);
    end
    for (int k = 0; k < N_CH; k++) total -= starts[k];
    checks++;
    if (total != 0) begin
      errors++;
      $display("[TB] FAIL decode_no_start got %0d starts required 0", -total);
    end
  endtask

  task automatic test_bad_chk();
    set_sensor(1, {8'h41, 8'h00, 8'h18, 8'h00, 8'h00});
    expect_rsp(8'h1F, 8'h00);
    send_frame(8'h01, 8'h02);
    wait_quiet("bad_chk", 200);
    set_sensor(1, {8'h41, 8'h00, 8'h18, 8'h00, 8'h59});
  endtask

  task automatic test_timeout();
    int n;
    int d;
    for (int pass = 0; pass < 2; pass++) begin
      sns_enable = (pass == 1);
      sns_wrong  = (pass == 1);
      expect_rsp(8'h1F, 8'h00);
      send_frame(8'h01, 8'h01);
      n = 0;
      while (tx_start !== 1'b1 && n < 300) begin
        @(negedge clock);
        n++;
      end
      d = cyc - last_start_cyc;
      checks++;
      if (d < TMO || d > TMO + 2) begin
        errors++;
        $display("[TB] FAIL timeout_cycles pass%0d got %0d required %0d..%0d", pass, d, TMO, TMO + 2);
      end
      wait_quiet("timeout", 300);
    end
    sns_enable = 1'b1;
    sns_wrong  = 1'b0;
  endtask

  task automatic test_gap();
    expect_rsp(8'h09, 8'h19);
    send_byte(8'h01);
    repeat (60) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_busy got %b required 0", busy);
    end
    send_byte(8'h02);
    send_byte(8'h01);
    wait_quiet("gap_expired", 200);
    expect_rsp(8'h09, 8'h19);
    send_byte(8'h02);
    repeat (40) @(negedge clock);
    send_byte(8'h01);
    wait_quiet("gap_within", 200);
  endtask

  task automatic test_back_to_back();
    set_sensor(3, {8'h40, 8'h00, 8'h1A, 8'h00, 8'h5A});
    sns_delay = 30;
    expect_rsp(8'h09, 8'h19);
    send_frame(8'h02, 8'h01);
    send_byte(8'h00);
    send_byte(8'h07);
    wait_quiet("busy_drop", 300);
    sns_delay = 10;
    expect_rsp(8'h07, 8'h00);
    send_frame(8'h03, 8'h00);
    wait_quiet("after_drop", 200);
  endtask

  task automatic test_monitor();
    int base;
    int n;
    expect_rsp(8'h09, 8'h1A);
    send_frame(8'h03, 8'h03);
    wait_quiet("mon_cmd", 200);
    checks++;
    if (mon_active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mon_active_set got %b required 1", mon_active);
    end
    for (int r = 0; r < 4; r++) begin
      sns_enable = (r != 2);
      if (r == 2) expect_rsp(8'h1F, 8'h00);
      else        expect_rsp(8'h09, 8'h1A);
      base = starts[3];
      n = 0;
      while (starts[3] == base && n < 1200) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (starts[3] == base) begin
        errors++;
        $display("[TB] FAIL mon_read%0d got no start required start on ch3", r);
      end else if (r > 0) begin
        checks++;
        if (last_start_cyc - prev_start_cyc != MON) begin
          errors++;
          $display("[TB] FAIL mon_period read%0d got %0d required %0d",
                   r, last_start_cyc - prev_start_cyc, MON);
        end
      end
      wait_quiet("mon_read", 300);
    end
    sns_enable = 1'b1;
    checks++;
    if (mon_active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mon_after_error got %b required 1", mon_active);
    end
    expect_rsp(8'h0A, 8'h00);
    send_frame(8'h00, 8'h05);
    wait_quiet("mon_off", 100);
    checks++;
    if (mon_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mon_active_clear got %b required 0", mon_active);
    end
    base = starts[3];
    repeat (2500) @(negedge clock);
    checks++;
    if (starts[3] != base) begin
      errors++;
      $display("[TB] FAIL mon_stopped got %0d reads required 0", starts[3] - base);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int tx_base;
    int s_base = 0;
    tx_auto = 1'b0;
    exp_q.push_back(8'h09);
    send_frame(8'h02, 8'h01);
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({tx_start, tx_data, sensor_start, busy, mon_active} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs got tx_start=%b tx_data=%02h busy=%b required all 0",
               tx_start, tx_data, busy);
    end
    reset = 1'b0;
    tx_base = tx_cnt;
    for (int k = 0; k < N_CH; k++) s_base += starts[k];
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      tx_done = 1'b1;
      @(negedge clock);
      tx_done = 1'b0;
    end
    for (int k = 0; k < N_CH; k++) s_base -= starts[k];
    checks++;
    if (tx_cnt != tx_base || s_base != 0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet got %0d tx %0d starts %0d pending required 0 0 0",
               tx_cnt - tx_base, -s_base, exp_q.size());
    end
    exp_q.delete();
    tx_auto = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    test_reset();
    test_temp_read();
    test_status_hum();
    test_decode_errors();
    test_bad_chk();
    test_timeout();
    test_gap();
    test_back_to_back();
    test_monitor();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
